div_error_accum: RTL and testbench
==================================

DIV_ERROR_ACCUM -- requirements
Module: div_error_accum

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, declared first: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL have the following input ports:
- start  input  1  begin a measurement run.
- num_samples  input  16  number of samples in the run; sampled on an accepted start.
- in_valid  input  1  sample present.
- q_apx  input  8  quotient from the approximate divider array.
- r_apx  input  8  remainder from the approximate divider array.
- q_ref  input  8  quotient from the exact divider array.
- r_ref  input  8  remainder from the exact divider array.
REQ-003 The block SHALL have the following output ports:
- in_ready  output  1  sample accepted this cycle if in_valid=1.
- busy  output  1  run in progress.
- done  output  1  run complete; results stable.
- sum_abs_err  output  24  sum of |q_apx - q_ref| over the run.
- max_abs_err  output  8  largest |q_apx - q_ref| seen in the run.
- q_mismatch  output  16  count of samples with q_apx != q_ref.
- r_mismatch  output  16  count of samples with r_apx != r_ref.
- sample_cnt  output  16  samples accepted in the current or last run.

Function
REQ-004 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-005 In IDLE or DONE, start=1 SHALL do all of the following at the same edge:
- latch num_samples;
- clear sum_abs_err, max_abs_err, q_mismatch, r_mismatch and sample_cnt to 0;
- enter RUN if num_samples != 0, otherwise enter DONE.
REQ-006 start SHALL be ignored while in RUN.
REQ-007 in_ready SHALL equal 1 exactly when the state is RUN, and SHALL be a registered decode of state with no combinational dependency on in_valid.
REQ-008 A sample SHALL be accepted on any rising edge where in_valid=1 and in_ready=1; all statistics SHALL update on that same edge.
REQ-009 abs_err SHALL be the 8-bit unsigned magnitude of q_apx - q_ref: q_apx - q_ref if q_apx >= q_ref, else q_ref - q_apx (range 0..255).
REQ-010 On acceptance, the statistics SHALL update as follows:
- sum_abs_err += abs_err, zero-extended to 24 bits; no overflow is possible because 65535*255 < 2^24.
- max_abs_err = max(max_abs_err, abs_err).
- q_mismatch increments if q_apx != q_ref.
- r_mismatch increments if r_apx != r_ref.
- sample_cnt increments.
REQ-011 When the accepted sample makes sample_cnt equal to the latched num_samples, the state SHALL move to DONE on that same edge; done SHALL read 1 from the next cycle, and in_ready SHALL read 0 from the next cycle.
REQ-012 busy SHALL be 1 in RUN and 0 otherwise; done SHALL be 1 in DONE and 0 otherwise.
REQ-013 All statistic outputs SHALL hold their values in IDLE and DONE until the next accepted start or reset.
REQ-014 in_valid=0 during RUN SHALL leave all statistics and the state unchanged, with no timeout.
REQ-015 Changes to num_samples after start SHALL have no effect on the current run.
REQ-016 Output latency SHALL be one cycle: the statistics are registered and reflect every sample accepted up to and including the previous edge.

Reset
REQ-017 rst=1 at a rising edge SHALL force:
- state to IDLE;
- in_ready=0, busy=0, done=0;
- all statistic outputs to 0.
REQ-018 Reset SHALL take priority over start and over sample acceptance at the same edge.
REQ-019 Reset asserted mid-RUN SHALL discard the partial run, and any latched num_samples SHALL no longer apply.
REQ-020 The block SHALL leave reset in IDLE and SHALL require a new start before accepting samples.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Basic run: start with num_samples=3; samples (q_apx,q_ref,r_apx,r_ref) = (10,10,3,3), (12,9,1,1), (5,7,0,2). Required: sum_abs_err=5, max_abs_err=3, q_mismatch=2, r_mismatch=1, sample_cnt=3; done=1 on the cycle after the third acceptance; in_ready=0 from then.
- Zero-length run: start with num_samples=0. Required: next cycle done=1, busy=0, all statistics 0, in_ready never 1.
- Bubbles and ignored start: num_samples=2 with in_valid toggling 1,0,0,1, and start pulsed mid-run. Required: only 2 samples counted; start has no effect; done asserts after the 2nd acceptance.
- Extremes: one sample q_apx=0, q_ref=255. Required: abs_err=255, sum_abs_err=255, max_abs_err=255.
- Reset mid-run: rst pulsed after 1 of 4 samples. Required: next cycle state IDLE, all outputs 0; a following start with num_samples=1 and one sample gives sample_cnt=1.
- Restart from DONE: start issued again from DONE. Required: statistics clear on that edge and a new run completes with independent results.

Source files
------------

// File: rtl/div_error_accum.sv
// Accumulates error statistics between an approximate and an exact divider
// over a run of num_samples accepted samples (IDLE -> RUN -> DONE).
module div_error_accum (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num_samples,
    input  logic        in_valid,
    input  logic [7:0]  q_apx,
    input  logic [7:0]  r_apx,
    input  logic [7:0]  q_ref,
    input  logic [7:0]  r_ref,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic [23:0] sum_abs_err,
    output logic [7:0]  max_abs_err,
    output logic [15:0] q_mismatch,
    output logic [15:0] r_mismatch,
    output logic [15:0] sample_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        start_ok_s;
    logic        accept_s;
    logic [15:0] cnt_inc_s;
    logic [7:0]  abs_err_s;

    logic [15:0] target_r;
    logic        in_ready_r;
    logic        busy_r;
    logic        done_r;
    logic [23:0] sum_r;
    logic [7:0]  max_r;
    logic [15:0] q_mis_r;
    logic [15:0] r_mis_r;
    logic [15:0] cnt_r;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    // Next-state decode, start/sample acceptance and per-sample error magnitude
    always_comb begin
        next_state_s = state_r;
        start_ok_s   = 1'b0;
        accept_s     = 1'b0;
        cnt_inc_s    = cnt_r + 16'd1;
        abs_err_s    = abs_diff(q_apx, q_ref);
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    start_ok_s   = 1'b1;
                    next_state_s = (num_samples != 16'd0) ? RUN : DONE;
                end else begin
                    next_state_s = state_r;
                end
            end
            RUN: begin
                // in_ready tracks RUN exactly, so acceptance needs only in_valid here
                if (in_valid) begin
                    accept_s = 1'b1;
                    if (cnt_inc_s == target_r) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = RUN;
                    end
                end else begin
                    next_state_s = RUN;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, status flags and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            target_r   <= 16'd0;
            sum_r      <= 24'd0;
            max_r      <= 8'd0;
            q_mis_r    <= 16'd0;
            r_mis_r    <= 16'd0;
            cnt_r      <= 16'd0;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s == RUN);
            busy_r     <= (next_state_s == RUN);
            done_r     <= (next_state_s == DONE);
            if (start_ok_s) begin
                target_r <= num_samples;
                sum_r    <= 24'd0;
                max_r    <= 8'd0;
                q_mis_r  <= 16'd0;
                r_mis_r  <= 16'd0;
                cnt_r    <= 16'd0;
            end else if (accept_s) begin
                sum_r <= sum_r + {16'd0, abs_err_s};
                if (abs_err_s > max_r) begin
                    max_r <= abs_err_s;
                end
                if (q_apx != q_ref) begin
                    q_mis_r <= q_mis_r + 16'd1;
                end
                if (r_apx != r_ref) begin
                    r_mis_r <= r_mis_r + 16'd1;
                end
                cnt_r <= cnt_inc_s;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign sum_abs_err = sum_r;
    assign max_abs_err = max_r;
    assign q_mismatch  = q_mis_r;
    assign r_mismatch  = r_mis_r;
    assign sample_cnt  = cnt_r;

endmodule

// File: tb/tb_div_error_accum.sv
// Self-checking bench for div_error_accum: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_div_error_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic [7:0]  q_apx, r_apx, q_ref, r_ref;
    logic        in_ready, busy, done;
    logic [23:0] sum_abs_err;
    logic [7:0]  max_abs_err;
    logic [15:0] q_mismatch, r_mismatch, sample_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // model of the run: plain integers
    bit m_ok   = 1'b0;
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_target, m_sum, m_max, m_qm, m_rm, m_cnt;

    div_error_accum dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .q_apx(q_apx), .r_apx(r_apx), .q_ref(q_ref), .r_ref(r_ref),
        .in_ready(in_ready), .busy(busy), .done(done), .sum_abs_err(sum_abs_err),
        .max_abs_err(max_abs_err), .q_mismatch(q_mismatch), .r_mismatch(r_mismatch),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour evaluated on each rising edge
    always @(posedge clk) begin
        int ae;
        if (rst) begin
            m_ok = 1'b1; m_run = 1'b0; m_done = 1'b0;
            m_target = 0; m_sum = 0; m_max = 0; m_qm = 0; m_rm = 0; m_cnt = 0;
        end else if (!m_run && start) begin
            m_target = int'(num_samples);
            m_sum = 0; m_max = 0; m_qm = 0; m_rm = 0; m_cnt = 0;
            m_run  = (num_samples != 0);
            m_done = (num_samples == 0);
        end else if (m_run && in_valid) begin
            ae = int'(q_apx) - int'(q_ref);
            if (ae < 0) ae = -ae;
            m_sum += ae;
            if (ae > m_max) m_max = ae;
            if (q_apx != q_ref) m_qm++;
            if (r_apx != r_ref) m_rm++;
            m_cnt++;
            if (m_cnt == m_target) begin
                m_run = 1'b0; m_done = 1'b1;
            end
        end
    end

    // Compare all outputs against the model away from the active edge
    always @(negedge clk) begin
        if (m_ok) begin
            check("in_ready", 32'(in_ready), 32'(m_run));
            check("busy", 32'(busy), 32'(m_run));
            check("done", 32'(done), 32'(m_done));
            check("sum_abs_err", 32'(sum_abs_err), m_sum);
            check("max_abs_err", 32'(max_abs_err), m_max);
            check("q_mismatch", 32'(q_mismatch), m_qm);
            check("r_mismatch", 32'(r_mismatch), m_rm);
            check("sample_cnt", 32'(sample_cnt), m_cnt);
        end
    end

    task automatic step(input logic st, input logic [15:0] n, input logic v,
                        input logic [7:0] qa, input logic [7:0] qr,
                        input logic [7:0] ra, input logic [7:0] rr);
        start = st; num_samples = n; in_valid = v;
        q_apx = qa; q_ref = qr; r_apx = ra; r_ref = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 16'd0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic check_stats(input string tag, input int s, input int mx, input int qm,
                               input int rm, input int c);
        check({tag, ".sum"}, 32'(sum_abs_err), s);
        check({tag, ".max"}, 32'(max_abs_err), mx);
        check({tag, ".qm"}, 32'(q_mismatch), qm);
        check({tag, ".rm"}, 32'(r_mismatch), rm);
        check({tag, ".cnt"}, 32'(sample_cnt), c);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; num_samples = 16'd0; in_valid = 1'b0;
        q_apx = 8'd0; q_ref = 8'd0; r_apx = 8'd0; r_ref = 8'd0;
        @(posedge clk); #1;
        idle();
        rst = 1'b0;
        check("reset.busy", 32'(busy), 0);
        check("reset.done", 32'(done), 0);
        check("reset.in_ready", 32'(in_ready), 0);
        check_stats("reset", 0, 0, 0, 0, 0);
        // leaving reset requires a start: valid samples are ignored
        step(1'b0, 16'd5, 1'b1, 8'd1, 8'd9, 8'd1, 8'd2);
        check("post_reset.cnt", 32'(sample_cnt), 0);

        // Basic run
        step(1'b1, 16'd3, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        check("basic.busy", 32'(busy), 1);
        check("basic.in_ready", 32'(in_ready), 1);
        step(1'b0, 16'd99, 1'b1, 8'd10, 8'd10, 8'd3, 8'd3);
        step(1'b0, 16'd99, 1'b1, 8'd12, 8'd9, 8'd1, 8'd1);
        check("basic.done_early", 32'(done), 0);
        step(1'b0, 16'd99, 1'b1, 8'd5, 8'd7, 8'd0, 8'd2);
        check("basic.done", 32'(done), 1);
        check("basic.in_ready", 32'(in_ready), 0);
        check_stats("basic", 5, 3, 2, 1, 3);
        step(1'b0, 16'd0, 1'b1, 8'd50, 8'd0, 8'd1, 8'd0);
        check_stats("basic_hold", 5, 3, 2, 1, 3);

        // Zero-length run
        step(1'b1, 16'd0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        check("zero.done", 32'(done), 1);
        check("zero.busy", 32'(busy), 0);
        check("zero.in_ready", 32'(in_ready), 0);
        check_stats("zero", 0, 0, 0, 0, 0);
        step(1'b0, 16'd0, 1'b1, 8'd4, 8'd1, 8'd0, 8'd0);
        check("zero.in_ready2", 32'(in_ready), 0);
        check("zero.cnt2", 32'(sample_cnt), 0);

        // Bubbles and ignored start
        step(1'b1, 16'd2, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        step(1'b0, 16'd0, 1'b1, 8'd20, 8'd16, 8'd0, 8'd0);
        step(1'b0, 16'd0, 1'b0, 8'd99, 8'd0, 8'd9, 8'd0);
        step(1'b1, 16'd7, 1'b0, 8'd99, 8'd0, 8'd9, 8'd0);
        check("bubble.busy", 32'(busy), 1);
        check("bubble.cnt_mid", 32'(sample_cnt), 1);
        step(1'b0, 16'd0, 1'b1, 8'd3, 8'd4, 8'd5, 8'd6);
        check("bubble.done", 32'(done), 1);
        check_stats("bubble", 5, 4, 2, 1, 2);

        // Extremes
        step(1'b1, 16'd1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        step(1'b0, 16'd0, 1'b1, 8'd0, 8'd255, 8'd0, 8'd0);
        check("ext.done", 32'(done), 1);
        check_stats("ext", 255, 255, 1, 0, 1);

        // Reset mid-run
        step(1'b1, 16'd4, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        step(1'b0, 16'd0, 1'b1, 8'd8, 8'd2, 8'd1, 8'd0);
        rst = 1'b1;
        step(1'b1, 16'd9, 1'b1, 8'd8, 8'd2, 8'd1, 8'd0);
        rst = 1'b0;
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        check("rst.in_ready", 32'(in_ready), 0);
        check_stats("rst", 0, 0, 0, 0, 0);
        step(1'b0, 16'd0, 1'b1, 8'd8, 8'd2, 8'd1, 8'd0);
        check("rst.no_accept", 32'(sample_cnt), 0);
        step(1'b1, 16'd1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        step(1'b0, 16'd0, 1'b1, 8'd6, 8'd6, 8'd2, 8'd2);
        check("rst.done2", 32'(done), 1);
        check_stats("rst2", 0, 0, 0, 0, 1);

        // Restart from DONE
        step(1'b1, 16'd2, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        check("restart.busy", 32'(busy), 1);
        check("restart.done", 32'(done), 0);
        check_stats("restart_clr", 0, 0, 0, 0, 0);
        step(1'b0, 16'd0, 1'b1, 8'd100, 8'd90, 8'd1, 8'd2);
        step(1'b0, 16'd0, 1'b1, 8'd1, 8'd2, 8'd3, 8'd4);
        check("restart.done2", 32'(done), 1);
        check_stats("restart", 11, 10, 2, 2, 2);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [7:0] qa, qr, ra, rr;
            qa = 8'($urandom);
            qr = ($urandom_range(0, 2) == 0) ? qa : 8'($urandom);
            ra = 8'($urandom_range(0, 3));
            rr = 8'($urandom_range(0, 3));
            rst = ($urandom_range(0, 79) == 0);
            step(($urandom_range(0, 7) == 0), 16'($urandom_range(0, 6)),
                 1'($urandom_range(0, 2) != 0), qa, qr, ra, rr);
        end
        rst = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
